sha3_theta_terms: RTL and testbench

SHA3_THETA_TERMS -- requirements
Module: sha3_theta_terms

---
 rtl/sha3_theta_terms.sv | 117 +++++++++++
 tb/tb_sha3_theta_terms.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_theta_terms.sv
// Theta column parities: XORs five 5x64 rows and presents oterm[x] on the edge after the fifth accept.
// SKID=1 accepts the next state's rows while a result waits. Optional perf_count: SHA3_THETA_TERMS_PERF_EN.
module sha3_theta_terms #(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_row [5],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] oterm [5],
  output logic        busy
`ifdef SHA3_THETA_TERMS_PERF_EN
  ,
  output logic [31:0] perf_count
`endif
);

  generate
    if (SKID != 0 && SKID != 1) begin : g_bad_skid
      initial begin
        $display("sha3_theta_terms: SKID must be 0 or 1, got %0d", SKID);
        $finish;
      end
    end
  endgenerate

  logic [2:0]  count_q, count_d;
  logic [63:0] acc_q [5];
  logic [63:0] acc_d [5];
  logic [63:0] oterm_q [5];
  logic [63:0] oterm_d [5];
  logic        out_valid_q, out_valid_d;
  logic        accept, xfer, last_row;

  assign last_row = (count_q == 3'd4);

  // Only the fifth row needs the result slot; earlier rows just land in acc.
  generate
    if (SKID == 1) begin : g_skid
      assign in_ready = !last_row || !out_valid_q || out_ready;
    end else begin : g_noskid
      assign in_ready = !out_valid_q || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid_q && out_ready;

  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    for (int x = 0; x < 5; x++) begin
      acc_d[x]   = acc_q[x];
      oterm_d[x] = oterm_q[x];
    end
    if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (last_row) begin
        count_d     = 3'd0;
        out_valid_d = 1'b1;
        for (int x = 0; x < 5; x++) begin
          oterm_d[x] = acc_q[x] ^ in_row[x];
          acc_d[x]   = '0;
        end
      end else begin
        count_d = count_q + 3'd1;
        for (int x = 0; x < 5; x++) begin
          acc_d[x] = (count_q == 3'd0) ? in_row[x] : (acc_q[x] ^ in_row[x]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 3'd0;
      out_valid_q <= 1'b0;
      for (int x = 0; x < 5; x++) begin
        acc_q[x]   <= '0;
        oterm_q[x] <= '0;
      end
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      for (int x = 0; x < 5; x++) begin
        acc_q[x]   <= acc_d[x];
        oterm_q[x] <= oterm_d[x];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign oterm     = oterm_q;
  assign busy      = (count_q != 3'd0);

`ifdef SHA3_THETA_TERMS_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  assign perf_cnt_d = perf_cnt_q + 32'(xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_count = perf_cnt_q;
`endif

endmodule

// File: tb/tb_sha3_theta_terms.sv
// Bench for sha3_theta_terms: DUT a uses SKID=1, DUT b uses SKID=0; expected parities go through queues.
module tb_sha3_theta_terms;

  typedef logic [4:0][63:0] row_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [63:0] a_in_row [5];
  logic [63:0] a_oterm [5];
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [63:0] b_in_row [5];
  logic [63:0] b_oterm [5];
`ifdef SHA3_THETA_TERMS_PERF_EN
  logic [31:0] a_perf_count, b_perf_count;
`endif

  row_t sb_a[$];
  row_t sb_b[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sha3_theta_terms #(.SKID(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .oterm(a_oterm), .busy(a_busy)
`ifdef SHA3_THETA_TERMS_PERF_EN
    , .perf_count(a_perf_count)
`endif
  );

  sha3_theta_terms #(.SKID(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .oterm(b_oterm), .busy(b_busy)
`ifdef SHA3_THETA_TERMS_PERF_EN
    , .perf_count(b_perf_count)
`endif
  );

  function automatic row_t rnd_row();
    row_t r;
    for (int x = 0; x < 5; x++) r[x] = {$urandom, $urandom};
    return r;
  endfunction

  function automatic row_t get_a_oterm();
    row_t r;
    for (int x = 0; x < 5; x++) r[x] = a_oterm[x];
    return r;
  endfunction

  // One clock of DUT a: drive at negedge, sample handshakes before the edge, return #1 after it.
  task automatic cyc_a(input logic v, input row_t row, input logic ordy,
                       output logic acc, output logic xf, output row_t ot);
    @(negedge clk);
    a_in_valid = v;
    for (int x = 0; x < 5; x++) a_in_row[x] = row[x];
    a_out_ready = ordy;
    #1;
    acc = v && a_in_ready;
    xf  = a_out_valid && ordy;
    ot  = get_a_oterm();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input row_t row, input logic ordy,
                       output logic acc, output logic xf, output row_t ot);
    @(negedge clk);
    b_in_valid = v;
    for (int x = 0; x < 5; x++) b_in_row[x] = row[x];
    b_out_ready = ordy;
    #1;
    acc = v && b_in_ready;
    xf  = b_out_valid && ordy;
    for (int x = 0; x < 5; x++) ot[x] = b_oterm[x];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t e;
    e = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_cmp++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0/0", a_busy, b_busy); end
    n_cmp++; if (get_a_oterm() !== e) begin n_fail++; $display("FAIL reset_oterm got %h want 0", get_a_oterm()); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_basic();
    row_t r, ot, exp, e;
    logic acc, xf;
    exp = '0;
    for (int y = 0; y < 5; y++) begin
      r = '0;
      r[0] = 64'h1 << y;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid row %0d got %b want 0", y, a_out_valid); end
      cyc_a(1'b1, r, 1'b1, acc, xf, ot);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept row %0d got %b want 1", y, acc); end
      if (acc) exp ^= r;
    end
    sb_a.push_back(exp);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid got %b want 1", a_out_valid); end
    n_cmp++; if (a_oterm[0] !== 64'h1F) begin n_fail++; $display("FAIL basic_lane0 got %h want 1f", a_oterm[0]); end
    cyc_a(1'b0, '0, 1'b1, acc, xf, ot);
    n_cmp++;
    if (!xf || sb_a.size() == 0) begin n_fail++; $display("FAIL basic_xfer xfer %b queued %0d", xf, sb_a.size()); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL basic_oterm got %h want %h", ot, e); end
    end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %b want 0", a_out_valid); end
  endtask

  task automatic test_skid();
    row_t r, ot, exp, e;
    logic acc, xf;
    exp = '0;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r = rnd_row();
      cyc_a(1'b1, r, 1'b0, acc, xf, ot);
      if (i < 9) begin
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL skid_ready row %0d got %b want 1", i, acc); end
        exp ^= r;
        if (i == 4) begin sb_a.push_back(exp); exp = '0; end
      end else begin
        n_cmp++; if (acc !== 1'b0) begin n_fail++; $display("FAIL skid_stall row %0d got %b want 0", i, acc); end
      end
    end
    cyc_a(1'b1, r, 1'b1, acc, xf, ot);
    n_cmp++; if (acc !== 1'b1 || xf !== 1'b1) begin n_fail++; $display("FAIL skid_release acc %b xfer %b want 1 1", acc, xf); end
    n_cmp++;
    if (sb_a.size() == 0) begin n_fail++; $display("FAIL skid_state1 queue empty"); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL skid_state1 got %h want %h", ot, e); end
    end
    if (acc) begin exp ^= r; sb_a.push_back(exp); end
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_no_bubble got %b want 1", a_out_valid); end
    cyc_a(1'b0, '0, 1'b1, acc, xf, ot);
    n_cmp++;
    if (!xf || sb_a.size() == 0) begin n_fail++; $display("FAIL skid_state2 xfer %b queued %0d", xf, sb_a.size()); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL skid_state2 got %h want %h", ot, e); end
    end
  endtask

  task automatic test_noskid();
    row_t r, ot, exp, e;
    logic acc, xf;
    exp = '0;
    for (int i = 0; i < 5; i++) begin
      r = rnd_row();
      cyc_b(1'b1, r, 1'b0, acc, xf, ot);
      if (acc) exp ^= r;
    end
    sb_b.push_back(exp);
    exp = '0;
    r = rnd_row();
    for (int i = 0; i < 3; i++) begin
      cyc_b(1'b1, r, 1'b0, acc, xf, ot);
      n_cmp++; if (acc !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL noskid_stall cycle %0d acc %b busy %b want 0 0", i, acc, b_busy); end
    end
    for (int i = 0; i < 5; i++) begin
      cyc_b(1'b1, r, 1'b1, acc, xf, ot);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL noskid_accept row %0d got %b want 1", i, acc); end
      if (xf) begin
        n_cmp++;
        if (sb_b.size() == 0) begin n_fail++; $display("FAIL noskid_state1 queue empty"); end
        else begin
          e = sb_b.pop_front();
          if (ot !== e) begin n_fail++; $display("FAIL noskid_state1 got %h want %h", ot, e); end
        end
      end
      if (acc) exp ^= r;
      r = rnd_row();
    end
    sb_b.push_back(exp);
    cyc_b(1'b0, '0, 1'b1, acc, xf, ot);
    n_cmp++;
    if (!xf || sb_b.size() != 1) begin n_fail++; $display("FAIL noskid_state2 xfer %b queued %0d want 1 1", xf, sb_b.size()); end
    else begin
      e = sb_b.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL noskid_state2 got %h want %h", ot, e); end
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t ones, ot, exp, e;
    logic acc, xf;
    ones = '1;
    exp = '0;
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b1, ones, 1'b0, acc, xf, ot);
      if (acc) exp ^= ones;
    end
    sb_a.push_back(exp);
    exp = '0;
    for (int i = 0; i < 4; i++) cyc_a(1'b1, '0, 1'b0, acc, xf, ot);
    n_cmp++; if (get_a_oterm() !== ones || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold got %h valid %b want all-ones 1", get_a_oterm(), a_out_valid); end
    cyc_a(1'b1, '0, 1'b1, acc, xf, ot);
    n_cmp++; if (acc !== 1'b1 || xf !== 1'b1) begin n_fail++; $display("FAIL b2b_handshake acc %b xfer %b want 1 1", acc, xf); end
    n_cmp++;
    if (sb_a.size() == 0) begin n_fail++; $display("FAIL b2b_state1 queue empty"); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL b2b_state1 got %h want %h", ot, e); end
    end
    sb_a.push_back(exp);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", a_out_valid); end
    cyc_a(1'b0, '0, 1'b1, acc, xf, ot);
    n_cmp++;
    if (!xf || sb_a.size() == 0) begin n_fail++; $display("FAIL b2b_state2 xfer %b queued %0d", xf, sb_a.size()); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL b2b_state2 got %h want %h", ot, e); end
    end
  endtask

  task automatic test_reset_mid();
    row_t ones, pat, ot, exp, e;
    logic acc, xf;
    ones = '1;
    pat = {5{64'hA5A5_A5A5_A5A5_A5A5}};
    for (int i = 0; i < 3; i++) cyc_a(1'b1, ones, 1'b1, acc, xf, ot);
    n_cmp++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", a_busy); end
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_reset busy %b valid %b want 0 0", a_busy, a_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    exp = '0;
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b1, pat, 1'b1, acc, xf, ot);
      if (acc) exp ^= pat;
    end
    sb_a.push_back(exp);
    for (int x = 0; x < 5; x++) begin
      n_cmp++; if (a_oterm[x] !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_fail++; $display("FAIL rstmid_lane%0d got %h want a5a5a5a5a5a5a5a5", x, a_oterm[x]); end
    end
    cyc_a(1'b0, '0, 1'b1, acc, xf, ot);
    n_cmp++;
    if (!xf || sb_a.size() == 0) begin n_fail++; $display("FAIL rstmid_xfer xfer %b queued %0d", xf, sb_a.size()); end
    else begin
      e = sb_a.pop_front();
      if (ot !== e) begin n_fail++; $display("FAIL rstmid_oterm got %h want %h", ot, e); end
    end
  endtask

`ifdef SHA3_THETA_TERMS_PERF_EN
  task automatic test_perf();
    row_t r, ot, exp, e;
    logic acc, xf;
    int   rows;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp = '0;
    rows = 0;
    for (int c = 0; c < 17; c++) begin
      r = rnd_row();
      cyc_a(rows < 15, r, 1'b1, acc, xf, ot);
      if (xf) begin
        n_cmp++;
        if (sb_a.size() == 0) begin n_fail++; $display("FAIL perf_oterm queue empty"); end
        else begin
          e = sb_a.pop_front();
          if (ot !== e) begin n_fail++; $display("FAIL perf_oterm got %h want %h", ot, e); end
        end
      end
      if (acc) begin
        exp ^= r;
        rows++;
        if (rows % 5 == 0) begin sb_a.push_back(exp); exp = '0; end
      end
    end
    n_cmp++; if (a_perf_count !== 32'd3) begin n_fail++; $display("FAIL perf_count got %0d want 3", a_perf_count); end
  endtask
`endif

  initial begin
    for (int x = 0; x < 5; x++) begin
      a_in_row[x] = '0;
      b_in_row[x] = '0;
    end
    test_reset();
    test_basic();
    test_skid();
    test_noskid();
    test_back_to_back();
    test_reset_mid();
`ifdef SHA3_THETA_TERMS_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
